// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: bridges the core's instruction-ROM port to a slow req/ack
// instruction bus through a small word buffer. Hits return in the same cycle;
// a miss raises stallreq_o while one bus transaction fills the buffer. A bus
// timeout fills the entry with NOP_INST and sets the sticky bus_err_o.
// Optional feature macro: IFB_PREFETCH_EN (two entries plus next-word prefetch).
module inst_fetch_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_inst_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_data_i,
    output logic        bus_err_o
);

`ifdef IFB_PREFETCH_EN
    localparam int unsigned NENT = 2;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_PREF} state_t;
`else
    localparam int unsigned NENT = 1;
    typedef enum logic [0:0] {S_IDLE, S_REQ} state_t;
`endif

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  count;
    logic        valid [NENT];
    logic [29:0] tag   [NENT];
    logic [31:0] data  [NENT];
    logic [31:0] word_addr;
    logic        hit, miss, timed_out;
    logic [31:0] hit_data;
`ifdef IFB_PREFETCH_EN
    logic        hit_idx, fill_sel, mru;
`endif

    assign word_addr = cpu_addr_i & ~32'h3;
    assign miss      = cpu_ce_i & ~hit;
    assign timed_out = (count == TO_LAST);

    // Buffer lookup: same-cycle hit data, NOP when disabled or missing.
    always_comb begin
        hit      = 1'b0;
        hit_data = NOP_INST;
`ifdef IFB_PREFETCH_EN
        hit_idx  = 1'b0;
`endif
        for (int unsigned i = 0; i < NENT; i++) begin
            if (cpu_ce_i && valid[i] && tag[i] == word_addr[31:2]) begin
                hit      = 1'b1;
                hit_data = data[i];
`ifdef IFB_PREFETCH_EN
                hit_idx  = 1'(i);
`endif
            end
        end
        cpu_inst_o = hit_data;
        stallreq_o = miss;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state: demand on miss, return on ack (which beats timeout) or timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (miss) state_next = S_REQ;
`ifdef IFB_PREFETCH_EN
            S_REQ: begin
                if (bus_ack_i)      state_next = S_PREF;
                else if (timed_out) state_next = S_IDLE;
            end
            S_PREF: if (bus_ack_i || timed_out) state_next = S_IDLE;
`else
            S_REQ: if (bus_ack_i || timed_out) state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Bus request, latched address, timeout counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_o  <= 1'b0;
            bus_addr_o <= '0;
            bus_err_o  <= 1'b0;
            count      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (miss) begin
                        bus_req_o  <= 1'b1;
                        bus_addr_o <= word_addr;
                        count      <= '0;
                    end
                end
                S_REQ: begin
                    if (bus_ack_i) begin
`ifdef IFB_PREFETCH_EN
                        // Request stays up: the next-word prefetch follows directly.
                        bus_addr_o <= bus_addr_o + 32'd4;
                        count      <= '0;
`else
                        bus_req_o  <= 1'b0;
`endif
                    end else if (timed_out) begin
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
`ifdef IFB_PREFETCH_EN
                S_PREF: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                    end else if (timed_out) begin
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
`endif
                default: bus_req_o <= 1'b0;
            endcase
        end
    end

`ifdef IFB_PREFETCH_EN
    // Buffer fill: demand goes to the entry not most recently hit, prefetch to the other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NENT; i++) begin
                valid[i] <= 1'b0;
                tag[i]   <= '0;
                data[i]  <= NOP_INST;
            end
            fill_sel <= 1'b0;
            mru      <= 1'b0;
        end else begin
            if (hit) mru <= hit_idx;
            if (state == S_IDLE && miss) fill_sel <= ~mru;
            if (state == S_REQ && (bus_ack_i || timed_out)) begin
                valid[fill_sel] <= 1'b1;
                tag[fill_sel]   <= bus_addr_o[31:2];
                data[fill_sel]  <= bus_ack_i ? bus_data_i : NOP_INST;
                if (bus_ack_i) fill_sel <= ~fill_sel;
            end
            if (state == S_PREF) begin
                if (bus_ack_i) begin
                    valid[fill_sel] <= 1'b1;
                    tag[fill_sel]   <= bus_addr_o[31:2];
                    data[fill_sel]  <= bus_data_i;
                end else if (timed_out) begin
                    valid[fill_sel] <= 1'b0;
                end
            end
        end
    end
`else
    // Buffer fill: the single entry is overwritten on every completed transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid[0] <= 1'b0;
            tag[0]   <= '0;
            data[0]  <= NOP_INST;
        end else if (state == S_REQ && (bus_ack_i || timed_out)) begin
            valid[0] <= 1'b1;
            tag[0]   <= bus_addr_o[31:2];
            data[0]  <= bus_ack_i ? bus_data_i : NOP_INST;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed self-checking bench for inst_fetch_bridge (TIMEOUT=4).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_inst_fetch_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_inst_o;
    logic        stallreq_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ack_i;
    logic [31:0] bus_data_i;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;

    inst_fetch_bridge #(.TIMEOUT(4), .NOP_INST(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_inst_o (cpu_inst_o),
        .stallreq_o (stallreq_o),
        .bus_req_o  (bus_req_o),
        .bus_addr_o (bus_addr_o),
        .bus_ack_i  (bus_ack_i),
        .bus_data_i (bus_data_i),
        .bus_err_o  (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cpu_ce_i = 1'b0; cpu_addr_i = '0; bus_ack_i = 1'b0; bus_data_i = '0;

        // T1: reset held while ack toggles
        for (int i = 0; i < 4; i++) begin
            tick();
            bus_ack_i = ~bus_ack_i;
            #1;
            check("t1_req",   32'(bus_req_o), 32'd0);
            check("t1_err",   32'(bus_err_o), 32'd0);
            check("t1_inst",  cpu_inst_o, 32'h0);
            check("t1_stall", 32'(stallreq_o), 32'd0);
            check("t1_addr",  bus_addr_o, 32'h0);
        end
        tick();
        rst = 1'b0; bus_ack_i = 1'b0;

`ifdef IFB_PREFETCH_EN
        // T6: demand fill 0x100 then automatic prefetch of 0x104
        tick(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h100; #1;
        check("t6_miss_stall", 32'(stallreq_o), 32'd1);
        tick(); bus_ack_i = 1'b1; bus_data_i = 32'h3401_1100; #1;
        check("t6_req", 32'(bus_req_o), 32'd1);
        check("t6_addr", bus_addr_o, 32'h100);
        tick(); bus_ack_i = 1'b0; #1;
        check("t6_pref_req", 32'(bus_req_o), 32'd1);
        check("t6_pref_addr", bus_addr_o, 32'h104);
        check("t6_hit_stall", 32'(stallreq_o), 32'd0);
        check("t6_hit_inst", cpu_inst_o, 32'h3401_1100);
        tick(); bus_ack_i = 1'b1; bus_data_i = 32'h3402_0004; #1;
        tick(); bus_ack_i = 1'b0; cpu_addr_i = 32'h104; #1;
        check("t6_104_req", 32'(bus_req_o), 32'd0);
        check("t6_104_stall", 32'(stallreq_o), 32'd0);
        check("t6_104_inst", cpu_inst_o, 32'h3402_0004);
        tick(); #1;
        check("t6_104_noreq", 32'(bus_req_o), 32'd0);
        cpu_addr_i = 32'hFFFF_FFFC; #1;
        check("t6_wrap_stall", 32'(stallreq_o), 32'd1);
        tick(); bus_ack_i = 1'b1; bus_data_i = 32'h0000_0005; #1;
        check("t6_wrap_addr", bus_addr_o, 32'hFFFF_FFFC);
        tick(); bus_ack_i = 1'b0; #1;
        check("t6_wrap_pref_addr", bus_addr_o, 32'h0);
        check("t6_wrap_pref_req", 32'(bus_req_o), 32'd1);
        check("t6_wrap_inst", cpu_inst_o, 32'h0000_0005);
        check("t6_wrap_hit", 32'(stallreq_o), 32'd0);
`else
        // T2: miss at 0x100, ack in the third REQ cycle -> 4 stall cycles
        tick(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h100; #1;
        check("t2_stall0", 32'(stallreq_o), 32'd1);
        check("t2_req0", 32'(bus_req_o), 32'd0);
        tick(); #1;
        check("t2_req1", 32'(bus_req_o), 32'd1);
        check("t2_addr", bus_addr_o, 32'h100);
        check("t2_stall1", 32'(stallreq_o), 32'd1);
        tick(); #1;
        check("t2_stall2", 32'(stallreq_o), 32'd1);
        tick(); bus_ack_i = 1'b1; bus_data_i = 32'h3401_1100; #1;
        check("t2_stall3", 32'(stallreq_o), 32'd1);
        check("t2_req3", 32'(bus_req_o), 32'd1);
        tick(); bus_ack_i = 1'b0; bus_data_i = '0; #1;
        check("t2_stall4", 32'(stallreq_o), 32'd0);
        check("t2_inst", cpu_inst_o, 32'h3401_1100);
        check("t2_req4", 32'(bus_req_o), 32'd0);

        // T3: hit on repeat and with low address bits set
        tick(); cpu_addr_i = 32'h102; #1;
        check("t3_stall", 32'(stallreq_o), 32'd0);
        check("t3_inst", cpu_inst_o, 32'h3401_1100);
        tick(); #1;
        check("t3_req", 32'(bus_req_o), 32'd0);

        // T4: timeout at 0x200 after 4 REQ cycles
        tick(); cpu_addr_i = 32'h200; #1;
        check("t4_stall", 32'(stallreq_o), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check("t4_req_held", 32'(bus_req_o), 32'd1);
            check("t4_err_low", 32'(bus_err_o), 32'd0);
        end
        tick(); #1;
        check("t4_req_drop", 32'(bus_req_o), 32'd0);
        check("t4_err", 32'(bus_err_o), 32'd1);
        check("t4_inst", cpu_inst_o, 32'h0);
        check("t4_hit_nop", 32'(stallreq_o), 32'd0);
        tick(); cpu_ce_i = 1'b0; #1;
        check("t4_err_sticky", 32'(bus_err_o), 32'd1);
        check("t4_ce_low_stall", 32'(stallreq_o), 32'd0);

        // Reset mid-REQ drops the request without a clock edge
        tick(); cpu_ce_i = 1'b1; cpu_addr_i = 32'h600; #1;
        check("rst_miss", 32'(stallreq_o), 32'd1);
        tick(); #1;
        check("rst_req_up", 32'(bus_req_o), 32'd1);
        check("rst_req_addr", bus_addr_o, 32'h600);
        #2; rst = 1'b1; #1;
        check("rst_async_req", 32'(bus_req_o), 32'd0);
        check("rst_async_addr", bus_addr_o, 32'h0);
        check("rst_async_err", 32'(bus_err_o), 32'd0);
        tick(); tick();
        rst = 1'b0; cpu_addr_i = 32'h200; #1;
        check("rst_buf_cleared", 32'(stallreq_o), 32'd1);

        // T5a: ack coincides with the timeout cycle -> ack wins
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            check("t5a_req", 32'(bus_req_o), 32'd1);
        end
        tick(); bus_ack_i = 1'b1; bus_data_i = 32'hAAAA_5555; #1;
        check("t5a_req_last", 32'(bus_req_o), 32'd1);
        tick(); bus_ack_i = 1'b0; #1;
        check("t5a_req_drop", 32'(bus_req_o), 32'd0);
        check("t5a_err", 32'(bus_err_o), 32'd0);
        check("t5a_inst", cpu_inst_o, 32'hAAAA_5555);
        check("t5a_stall", 32'(stallreq_o), 32'd0);

        // T5b: ce drop and address change mid-REQ; fill completes for latched address
        tick(); cpu_addr_i = 32'h400; #1;
        check("t5b_miss", 32'(stallreq_o), 32'd1);
        tick(); cpu_ce_i = 1'b0; cpu_addr_i = 32'h500; #1;
        check("t5b_req", 32'(bus_req_o), 32'd1);
        check("t5b_addr", bus_addr_o, 32'h400);
        check("t5b_ce_low_stall", 32'(stallreq_o), 32'd0);
        check("t5b_ce_low_inst", cpu_inst_o, 32'h0);
        tick(); bus_ack_i = 1'b1; bus_data_i = 32'h1111_2222; #1;
        check("t5b_addr_stable", bus_addr_o, 32'h400);
        tick(); bus_ack_i = 1'b0; #1;
        check("t5b_req_drop", 32'(bus_req_o), 32'd0);
        check("t5b_err", 32'(bus_err_o), 32'd0);
        // Ack while idle must be ignored
        tick(); bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF; #1;
        tick(); bus_ack_i = 1'b0; #1;
        check("t5b_idle_ack_req", 32'(bus_req_o), 32'd0);
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h400; #1;
        check("t5b_hit_stall", 32'(stallreq_o), 32'd0);
        check("t5b_hit_inst", cpu_inst_o, 32'h1111_2222);
        cpu_addr_i = 32'h500; #1;
        check("t5b_other_miss", 32'(stallreq_o), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
